// File: rtl/execute_unit_pkg.sv
// execute_unit_pkg: shared instruction, opcode and divider-state types for the execute stage
package execute_unit_pkg;
  typedef enum logic [3:0] {
    EX_ADD, EX_SUB, EX_AND, EX_OR, EX_XOR, EX_SLL, EX_SRL, EX_SRA,
    EX_SLT, EX_SLTU, EX_LUI, EX_MUL, EX_DIV, EX_DIVU, EX_REM, EX_REMU
  } ex_op_e;
  typedef struct packed {
    ex_op_e     exop;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic [4:0] rd;
  } inst_t;
  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_FIX, DIV_DONE} div_state_e;
  function automatic logic is_div_op(input ex_op_e op);
    return op inside {EX_DIV, EX_DIVU, EX_REM, EX_REMU};
  endfunction
endpackage

// File: rtl/execute_unit_divider.sv
// divider_radix2: restoring radix-2 divider on magnitudes with a final sign-fixup cycle
module divider_radix2
  import execute_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 33
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            signed_op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 2);
  div_state_e state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [XLEN-1:0] quo_q, rem_q, dsr_q;
  logic qneg_q, rneg_q, take;
  logic [XLEN:0] shifted;
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic s);
    return (s && x[XLEN-1]) ? -x : x;
  endfunction
  assign busy = state_q == DIV_RUN || state_q == DIV_FIX;
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign take = shifted >= {1'b0, dsr_q};
  assign quotient = quo_q;
  assign remainder = rem_q;
  always_comb
    state_d = abort ? DIV_IDLE :
              (start && !busy) ? DIV_RUN :
              (state_q == DIV_RUN && cnt_q == LAST) ? DIV_FIX :
              (state_q == DIV_FIX) ? DIV_DONE : state_q;
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == DIV_RUN && !abort) ? cnt_q + 1'b1 : '0;
      if (start && !busy) begin
        quo_q  <= mag(dividend, signed_op);
        rem_q  <= '0;
        dsr_q  <= mag(divisor, signed_op);
        // a zero divisor keeps the all-ones quotient whatever the signs
        qneg_q <= signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]) && |divisor;
        rneg_q <= signed_op && dividend[XLEN-1];
      end else if (state_q == DIV_RUN) begin
        quo_q <= {quo_q[XLEN-2:0], take};
        rem_q <= take ? XLEN'(shifted - {1'b0, dsr_q}) : shifted[XLEN-1:0];
      end else if (state_q == DIV_FIX) begin
        quo_q <= qneg_q ? -quo_q : quo_q;
        rem_q <= rneg_q ? -rem_q : rem_q;
      end
    end
endmodule

// File: rtl/execute_unit.sv
// execute_unit: DE pipeline registers, ALU, two-cycle multiplier and iterative divider feeding the memory stage
module execute_unit
  import execute_unit_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 33
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            flush,
  output logic            fin,
  input  inst_t           inst,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  output inst_t           inst_out,
  output logic [XLEN-1:0] aluresult,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] rdata1
);
  inst_t inst_q;
  logic [XLEN-1:0] src1_q, src2_q, imm_q, mul_q, op_b, alu, quotient, remainder;
  logic [4:0] sh;
  logic mul_pend_q, busy, capture;
  assign capture = enable && !flush && !busy;
  assign op_b = inst_q.alusrc ? imm_q : src2_q;
  assign sh = op_b[4:0];
  always_ff @(posedge clk)
    if (rst || flush) begin
      inst_q     <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      imm_q      <= '0;
      mul_q      <= '0;
      mul_pend_q <= 1'b0;
    end else begin
      if (capture) begin
        inst_q <= inst;
        src1_q <= src1;
        src2_q <= src2;
        imm_q  <= imm;
      end
      mul_pend_q <= capture && inst.exop == EX_MUL;
      mul_q      <= src1_q * op_b;
    end
  always_comb begin
    alu = src1_q + op_b;
    case (inst_q.exop)
      EX_SUB:  alu = src1_q - op_b;
      EX_AND:  alu = src1_q & op_b;
      EX_OR:   alu = src1_q | op_b;
      EX_XOR:  alu = src1_q ^ op_b;
      EX_SLL:  alu = src1_q << sh;
      EX_SRL:  alu = src1_q >> sh;
      EX_SRA:  alu = $signed(src1_q) >>> sh;
      EX_SLT:  alu = {{(XLEN-1){1'b0}}, $signed(src1_q) < $signed(op_b)};
      EX_SLTU: alu = {{(XLEN-1){1'b0}}, src1_q < op_b};
      EX_LUI:  alu = op_b;
      default: ;
    endcase
  end
  divider_radix2 #(.XLEN(XLEN), .DIV_CYCLES(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (capture && is_div_op(inst.exop)),
    .abort     (flush),
    .signed_op (inst.exop == EX_DIV || inst.exop == EX_REM),
    .dividend  (src1),
    .divisor   (inst.alusrc ? imm : src2),
    .busy      (busy),
    .quotient  (quotient),
    .remainder (remainder)
  );
  assign fin = !busy && !mul_pend_q;
  assign inst_out = inst_q;
  assign aluresult = src1_q + imm_q;
  assign rdata1 = src2_q;
  assign result = is_div_op(inst_q.exop)
                ? ((inst_q.exop == EX_DIV || inst_q.exop == EX_DIVU) ? quotient : remainder)
                : (inst_q.exop == EX_MUL) ? mul_q : alu;
endmodule

// File: doc/execute_unit.md
Name: execute_unit

Overview:
- Execute stage directly upstream of the memory stage.
- Latches decoded instruction and forwarded operands into DE pipeline registers when `enable` is high.
- Computes the ALU result, the effective address and the store data, presented combinationally to the memory stage from the DE registers.
- Single-cycle ops finish immediately. MUL takes 2 cycles. DIV/DIVU/REM/REMU use a radix-2 iterative divider that holds `fin` low until the result is ready.

Parameters:
- XLEN, 32, datapath width (only 32 supported).
- DIV_CYCLES, 33, fixed divider latency: 32 iterations + 1 sign-fixup cycle.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  capture DE inputs at this edge (global stall control)
- flush  in  1  replace DE contents with bubble; abort divider
- fin  out  1  stage done; result outputs valid
- inst  in  Inst  decoded instruction (uses fields exop, alusrc, memread, memwrite, regwrite, rd)
- src1  in  32  forwarded rs1 value
- src2  in  32  forwarded rs2 value
- imm  in  32  sign-extended immediate
- inst_out  out  Inst  DE-registered instruction
- aluresult  out  32  effective address: src1_DE + imm_DE
- result  out  32  operation result
- rdata1  out  32  store data: src2_DE

Behaviour:
- Reset, when rst is high at a clock edge:
  - DE regs cleared to bubble (inst all-zero, operands 0).
  - Divider state set to IDLE, counter 0.
  - `fin`=1; `aluresult`, `result`, `rdata1`=0.
- Capture:
  - At a clock edge with `enable`=1, `flush`=0 and state IDLE: DE regs load `inst`, `src1`, `src2`, `imm`.
  - Operand b = `alusrc` ? `imm` : `src2`.
- Flush:
  - `flush`=1 has priority over `enable`.
  - DE gets a bubble, state goes to IDLE, `fin`=1 next cycle.
- Single-cycle ops (ADD SUB AND OR XOR SLL SRL SRA SLT SLTU LUI-pass):
  - `result` is valid in the cycle after capture; `fin`=1.
  - Shift amount is b[4:0].
  - SLT is signed, SLTU is unsigned.
- MUL:
  - Low 32 bits of a*b, with one registered stage.
  - `fin`=0 for exactly 1 cycle after capture, then `fin`=1 with `result` valid.
- Divider FSM, states IDLE → DIV → FIX → DONE.
  - Capture of a div-class op sets state DIV and cnt=0 at the same edge.
  - Magnitudes of the operands are loaded; signs are recorded for the signed variants.
  - DIV: one quotient bit per cycle; cnt increments 0..31; at cnt=31 → FIX.
  - FIX: applies signs (quotient negative iff signs differ; remainder takes the dividend's sign) → DONE.
  - `fin`=0 in DIV and FIX, i.e. 33 cycles.
  - `fin`=1 in DONE; `result` holds the selected quotient or remainder.
  - DONE → IDLE at the next edge with `enable`=1, which is also a capture edge.
- Divide by zero:
  - Quotient = 0xFFFFFFFF; remainder = dividend.
  - Same 33-cycle latency.
- Signed overflow (0x80000000 / 0xFFFFFFFF):
  - Quotient = 0x80000000, remainder = 0.
  - Same latency.
- `enable`=1 while state is DIV or FIX: ignored, and DE regs hold. The controller normally never does this.
- `aluresult` is computed for every op with modulo-2^32 wrap, no overflow flag.
- `inst_out`, `rdata1` and `aluresult` are stable for the whole time an instruction sits in DE, including divider stalls.
- Reset during DIV: immediate abort, as for reset.

Decomposition:
- def.sv (shared package) holds:
  - `ExOp` enum: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU LUI MUL DIV DIVU REM REMU.
  - `exop` field added to the `Inst` struct.
  - DivState enum.
- One sub-module `divider_radix2`:
  - Inputs: clk, rst, start, abort, signed_op, dividend, divisor.
  - Outputs: busy, quotient, remainder.
- ALU stays combinational inside execute_unit.

Test Plan:
- Reset, then ADD with src1=5, src2=7 and enable pulse → next cycle `result`=12, `fin`=1, `inst_out.rd` matches the input.
- SW-type with src1=0x1000, imm=0xFFFFFFFC, src2=0xDEADBEEF → `aluresult`=0x00000FFC, `rdata1`=0xDEADBEEF, `fin`=1.
- DIV with -7 / 2 → `fin` low for exactly 33 cycles, then `result`=0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF.
- DIVU 100/0 → quotient 0xFFFFFFFF; REMU 100/0 → 100; DIV 0x80000000/0xFFFFFFFF → 0x80000000.
- Flush at cycle 10 of a DIV → next cycle `fin`=1, `inst_out` is a bubble, and a subsequent ADD 1+1 gives 2.
- rst asserted at cycle 5 of a DIVU, with enable held high during the stall → all outputs 0, `fin`=1, and DE is not updated by enable during DIV.
